// File: rtl/bus_initiator_bridge.sv
// bus_initiator_bridge
//   Byte-stream-to-bus initiator. It parses a command byte stream (for example from a
//   UART RX), issues one access on the req/resp/fault bus, and waits for resp, fault or
//   timeout. It then returns a status byte, followed by read data, as a byte stream.
//
//   Command stream : OP {w_rb, 5'b0, sz[1:0]}, addr[4] LE, then wdata[4] LE for writes
//   Response stream: status (00 ok, 01 fault, 02 timeout, 03 bad opcode),
//                    then rdata[4] LE for an ok read only
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_data/valid/ready        command byte stream in
//   rsp_data/valid/ready        response byte stream out
//   addr, w_rb, acc, wdata      bus request fields, stable from the req cycle until the
//                               access completes
//   rdata, resp, fault          bus response; resp/fault are ignored outside the access
//   req                         single-cycle request strobe
//   busy                        high whenever the bridge is not idle waiting for an OP byte

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'b00
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'b01
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module bus_initiator_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cmd_data,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic [7:0]                rsp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic                      w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [`BUS_WIDTH-1:0]     wdata,
    input  logic [`BUS_WIDTH-1:0]     rdata,
    output logic                      req,
    input  logic                      resp,
    input  logic                      fault,
    output logic                      busy
);

    typedef enum logic [2:0] {
        StOp,
        StAddr,
        StWdata,
        StReq,
        StWait,
        StStat,
        StRdata
    } state_e;

    localparam logic [7:0] StatusOk      = 8'h00;
    localparam logic [7:0] StatusFault   = 8'h01;
    localparam logic [7:0] StatusTimeout = 8'h02;
    localparam logic [7:0] StatusBadOp   = 8'h03;

    // The timer counts wait cycles 0..TIMEOUT-1; the last value triggers the timeout.
    localparam int unsigned TimerWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT - 1);

    state_e                      state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [TimerWidth-1:0]       timer_q, timer_d;
    logic [31:0]                 addr_buf_q, addr_buf_d;
    logic                        w_rb_q, w_rb_d;
    logic [`BUS_ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [`BUS_WIDTH-1:0]       wdata_q, wdata_d;
    logic [`BUS_WIDTH-1:0]       rdata_q, rdata_d;
    logic [7:0]                  status_q, status_d;
    logic [7:0]                  rsp_data_q, rsp_data_d;
    logic                        req_q, req_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        busy_q, busy_d;

    logic       cmd_hs;
    logic       rsp_hs;
    logic       op_bad;
    logic [1:0] cnt_inc;

    assign cmd_hs  = cmd_valid & cmd_ready_q;
    assign rsp_hs  = rsp_valid_q & rsp_ready;
    assign op_bad  = (cmd_data[6:2] != 5'd0) || (cmd_data[1:0] == 2'd3);
    assign cnt_inc = cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        addr_buf_d = addr_buf_q;
        w_rb_d     = w_rb_q;
        acc_d      = acc_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        rsp_data_d = rsp_data_q;

        unique case (state_q)
            StOp: begin
                if (cmd_hs) begin
                    if (op_bad) begin
                        // Reject without consuming any further bytes or touching the bus.
                        status_d   = StatusBadOp;
                        rsp_data_d = StatusBadOp;
                        state_d    = StStat;
                    end else begin
                        w_rb_d = cmd_data[7];
                        case (cmd_data[1:0])
                            2'd0:    acc_d = `BUS_ACC_1B;
                            2'd1:    acc_d = `BUS_ACC_2B;
                            default: acc_d = `BUS_ACC_4B;
                        endcase
                        cnt_d   = 2'd0;
                        state_d = StAddr;
                    end
                end
            end

            StAddr: begin
                if (cmd_hs) begin
                    addr_buf_d[{cnt_q, 3'b000} +: 8] = cmd_data;
                    cnt_d = cnt_inc;
                    if (cnt_q == 2'd3) begin
                        state_d = w_rb_q ? StWdata : StReq;
                    end
                end
            end

            StWdata: begin
                if (cmd_hs) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = cmd_data;
                    cnt_d = cnt_inc;
                    if (cnt_q == 2'd3) begin
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                // fault is only meaningful in the req cycle itself.
                if (fault) begin
                    status_d   = StatusFault;
                    rsp_data_d = StatusFault;
                    state_d    = StStat;
                end else begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end

            StWait: begin
                // resp takes priority over a timeout expiring in the same cycle.
                if (resp) begin
                    rdata_d    = rdata;
                    status_d   = StatusOk;
                    rsp_data_d = StatusOk;
                    state_d    = StStat;
                end else if (timer_q == TimerLast) begin
                    status_d   = StatusTimeout;
                    rsp_data_d = StatusTimeout;
                    state_d    = StStat;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end

            StStat: begin
                if (rsp_hs) begin
                    if ((status_q == StatusOk) && !w_rb_q) begin
                        cnt_d      = 2'd0;
                        rsp_data_d = rdata_q[7:0];
                        state_d    = StRdata;
                    end else begin
                        state_d = StOp;
                    end
                end
            end

            StRdata: begin
                if (rsp_hs) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == 2'd3) begin
                        state_d = StOp;
                    end else begin
                        rsp_data_d = rdata_q[{cnt_inc, 3'b000} +: 8];
                    end
                end
            end

            default: state_d = StOp;
        endcase

        // Outputs are registered from the next state so they change with the state flop.
        req_d       = (state_d == StReq);
        cmd_ready_d = (state_d == StOp) || (state_d == StAddr) || (state_d == StWdata);
        rsp_valid_d = (state_d == StStat) || (state_d == StRdata);
        busy_d      = (state_d != StOp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StOp;
            cnt_q       <= 2'd0;
            timer_q     <= '0;
            addr_buf_q  <= 32'd0;
            w_rb_q      <= 1'b0;
            acc_q       <= `BUS_ACC_4B;
            wdata_q     <= '0;
            rdata_q     <= '0;
            status_q    <= 8'd0;
            rsp_data_q  <= 8'd0;
            req_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            addr_buf_q  <= addr_buf_d;
            w_rb_q      <= w_rb_d;
            acc_q       <= acc_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            rsp_data_q  <= rsp_data_d;
            req_q       <= req_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Address bytes beyond ADDR_WIDTH are simply not forwarded.
    assign addr      = addr_buf_q[ADDR_WIDTH-1:0];
    assign w_rb      = w_rb_q;
    assign acc       = acc_q;
    assign wdata     = wdata_q;
    assign req       = req_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bus_initiator_bridge.sv
// Testbench for bus_initiator_bridge: table-driven transactions, plus directed sequences
// for timeout, bad opcode, reset mid-command and response back-pressure.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif

module tb_bus_initiator_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic        resp;
    logic        fault;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int req_count = 0;

    bus_initiator_bridge #(
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .rsp_data (rsp_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .addr     (addr),
        .w_rb     (w_rb),
        .acc      (acc),
        .wdata    (wdata),
        .rdata    (rdata),
        .req      (req),
        .resp     (resp),
        .fault    (fault),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req) req_count++;
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        int          rdelay;
        bit          flt;
        logic [31:0] rd;
        logic [7:0]  st;
        logic [1:0]  eacc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_byte_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk(name, {24'd0, rsp_data}, {24'd0, exp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"},       {31'd0, req},       32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_addr"},      addr,               32'd0);
        chk({tag, "_w_rb"},      {31'd0, w_rb},      32'd0);
        chk({tag, "_acc"},       {30'd0, acc},       32'd2);
        chk({tag, "_wdata"},     wdata,              32'd0);
        chk({tag, "_rsp_data"},  {24'd0, rsp_data},  32'd0);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input int rdelay, input bit flt, input logic [31:0] rd,
                           input logic [7:0] st, input logic [1:0] eacc, input int stall);
        bit wr;
        wr = op[7];
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
        // One cycle after the last byte is accepted, req must be up.
        chk("req_on", {31'd0, req}, 32'd1);
        chk("addr",   addr, a);
        chk("w_rb",   {31'd0, w_rb}, {31'd0, wr});
        chk("acc",    {30'd0, acc}, {30'd0, eacc});
        if (wr) chk("wdata", wdata, wd);
        fault = flt;
        tick();
        fault = 1'b0;
        chk("req_pulse", {31'd0, req}, 32'd0);
        if (!flt) begin
            chk("busy_wait", {31'd0, busy}, 32'd1);
            for (int k = 1; k < rdelay; k++) tick();
            chk("addr_hold", addr, a);
            resp  = 1'b1;
            rdata = rd;
            tick();
            resp  = 1'b0;
            rdata = 32'hFFFF_FFFF;
        end
        chk("stat_latency", {31'd0, rsp_valid}, 32'd1);
        for (int k = 0; k < stall; k++) begin
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", {24'd0, rsp_data}, {24'd0, st});
            tick();
        end
        recv_byte("status", st);
        if (st == 8'h00 && !wr) begin
            for (int i = 0; i < 4; i++) recv_byte("rdata_byte", rd[8*i +: 8]);
        end
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy",      {31'd0, busy},      32'd0);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int k;
        int req_before;

        vecs[0] = '{8'h02, 32'h0000_0000, 32'h0,         2, 1'b0, 32'h1234_5678, 8'h00, 2'd2};
        vecs[1] = '{8'h82, 32'h0000_0004, 32'hDEAD_BEEF, 1, 1'b0, 32'h0,         8'h00, 2'd2};
        vecs[2] = '{8'h02, 32'h0000_0008, 32'h0,         1, 1'b1, 32'h0,         8'h01, 2'd2};
        vecs[3] = '{8'h00, 32'h1020_3040, 32'h0,         1, 1'b0, 32'hA5C3_0F96, 8'h00, 2'd0};
        vecs[4] = '{8'h81, 32'h0000_0100, 32'h0000_BEEF, 3, 1'b0, 32'h0,         8'h00, 2'd1};
        vecs[5] = '{8'h82, 32'h0000_000C, 32'h5555_AAAA, 1, 1'b1, 32'h0,         8'h01, 2'd2};

        rst = 1'b1;
        cmd_data = 8'h00;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rdata = 32'h0;
        resp = 1'b0;
        fault = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].op, vecs[v].a, vecs[v].wd, vecs[v].rdelay, vecs[v].flt,
                    vecs[v].rd, vecs[v].st, vecs[v].eacc, 0);
        end

        // Timeout: no resp; status must appear exactly 5 cycles after the req cycle.
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        chk("to_req_on", {31'd0, req}, 32'd1);
        k = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (rsp_valid) begin
                k = c;
                break;
            end
        end
        chk("to_latency", k, 32'd5);
        resp = 1'b1;
        rdata = 32'h7777_7777;
        tick();
        resp = 1'b0;
        chk("to_late_resp_data", {24'd0, rsp_data}, 32'h02);
        recv_byte("to_status", 8'h02);
        chk("to_no_rdata", {31'd0, rsp_valid}, 32'd0);
        resp = 1'b1;
        tick();
        resp = 1'b0;
        chk("to_idle_busy", {31'd0, busy}, 32'd0);
        run_txn(8'h02, 32'h0000_0040, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 8'h00, 2'd2, 0);

        // Bad opcodes: no address bytes consumed and no request issued.
        req_before = req_count;
        send_byte(8'h43);
        chk("bad_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bad_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        recv_byte("bad_status", 8'h03);
        send_byte(8'h03);
        recv_byte("bad_sz_status", 8'h03);
        chk("bad_no_req", req_count, req_before);
        run_txn(8'h02, 32'h0000_0010, 32'h0, 2, 1'b0, 32'h8765_4321, 8'h00, 2'd2, 0);

        // Leave write state in the bus fields so reset has something to clear.
        run_txn(8'h80, 32'h0000_0200, 32'h1357_9BDF, 1, 1'b0, 32'h0, 8'h00, 2'd0, 0);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        reset_dut();
        check_reset_state("rst_mid_addr");

        run_txn(8'h82, 32'h0000_0300, 32'hFEDC_BA98, 1, 1'b0, 32'h0, 8'h00, 2'd2, 0);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'h50);
        tick();
        chk("rst_wait_busy", {31'd0, busy}, 32'd1);
        reset_dut();
        check_reset_state("rst_in_wait");
        resp = 1'b1;
        tick();
        resp = 1'b0;
        chk("rst_late_resp", {31'd0, rsp_valid}, 32'd0);

        // Full read after reset with the response stream held off for 10 cycles.
        run_txn(8'h02, 32'h0000_0044, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 8'h00, 2'd2, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
